// File: rtl/dl_pkg.sv
// Shared definitions for the delay-line command scheduler.
// Holds the host opcode map, sequencing constants, the scheduler state
// encoding and the period reload helper used by the auto-sample timer.
package dl_pkg;

   localparam int unsigned P_EDGE_WAIT    = 20;
   localparam int unsigned P_UNLOAD_BYTES = 7;
   localparam int unsigned P_TIMER_W      = 24;

   localparam int unsigned WAIT_W   = $clog2(P_EDGE_WAIT);
   localparam int unsigned UNLOAD_W = $clog2(P_UNLOAD_BYTES + 1);

   localparam logic [3:0] OP_LOAD    = 4'h0;
   localparam logic [3:0] OP_UNLOAD  = 4'h1;
   localparam logic [3:0] OP_CAPTURE = 4'h2;
   localparam logic [3:0] OP_EDGE    = 4'h3;
   localparam logic [3:0] OP_PERIOD  = 4'h4;
   localparam logic [3:0] OP_AUTO    = 4'h5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HOST   = 3'd1,
      EDGE   = 3'd2,
      WAIT   = 3'd3,
      UNLOAD = 3'd4,
      DRAIN  = 3'd5
   } sched_state_t;

   // Auto-sample period reload value: (1 << (exponent + 8)) - 1.
   function automatic logic [P_TIMER_W-1:0] period_reload(input logic [3:0] exponent);
      logic [31:0] span;
      span = 32'(1) << (5'(exponent) + 5'd8);
      return P_TIMER_W'(span - 32'd1);
   endfunction

endpackage

// File: rtl/dl_sched_timer.sv
// Auto-sample period timer.
// Holds the period exponent and the auto enable, runs the period
// down-counter and raises the sticky pending flag when it expires.
//   clk, rst_n   : clock, async active-low reset
//   set_period   : load exponent from arg; counter reloads one cycle later
//   set_auto     : load auto enable from arg[0]; disabling clears pending
//   arg          : argument nibble of the host byte
//   clr_pending  : scheduler has issued the edge burst
//   pending      : an auto sequence is owed
module dl_sched_timer
   import dl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_period,
   input  logic       set_auto,
   input  logic [3:0] arg,
   input  logic       clr_pending,
   output logic       pending
);

   logic [3:0]           exponent;
   logic                 auto_en;
   logic                 reload_req;
   logic [P_TIMER_W-1:0] timer;
   logic                 fire_c;

   // A pending reload takes precedence over expiry of the old count.
   assign fire_c = auto_en && !reload_req && (timer == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exponent   <= 4'd0;
         auto_en    <= 1'b0;
         reload_req <= 1'b0;
         timer      <= '0;
         pending    <= 1'b0;
      end else begin
         reload_req <= set_period;
         if (set_period) exponent <= arg;
         if (set_auto)   auto_en  <= arg[0];

         if (reload_req || fire_c) timer <= period_reload(exponent);
         else if (auto_en)         timer <= timer - P_TIMER_W'(1);

         // Fires do not queue; a fresh fire wins over the edge-issue clear.
         if (set_auto && !arg[0]) pending <= 1'b0;
         else if (fire_c)         pending <= 1'b1;
         else if (clr_pending)    pending <= 1'b0;
      end
   end

endmodule

// File: rtl/dl_sched.sv
// Command scheduler/arbiter for the delay-line driver command port.
// Forwards host command bytes through a one-entry buffer and interleaves
// periodic auto-sample sequences (edge burst, wait, paced unloads).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_rx_valid/data: host byte strobe and byte ([3:0] opcode, [7:4] arg)
//   o_cmd_valid/data: one-cycle command strobe and byte to the driver
//   i_tx_valid     : driver TX valid (not used for sequencing)
//   i_tx_accept    : UART TX accepted a driver byte
//   o_busy         : scheduler not idle or host byte waiting
//   o_overflow     : sticky, a host byte was dropped
module dl_sched
   import dl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx_valid,
   input  logic [7:0] i_rx_data,
   output logic       o_cmd_valid,
   output logic [7:0] o_cmd_data,
   input  logic       i_tx_valid,
   input  logic       i_tx_accept,
   output logic       o_busy,
   output logic       o_overflow
);

   sched_state_t        state, state_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic [UNLOAD_W-1:0] unload_cnt, unload_nxt;
   logic                buf_full, buf_full_nxt;
   logic [7:0]          buf_data, buf_data_nxt;
   logic                overflow_nxt;
   logic                cmd_valid_nxt;
   logic [7:0]          cmd_data_nxt;
   logic                busy_nxt;
   logic                drain_buf_c;
   logic                clr_pending_c;
   logic                pending;
   logic                host_byte_c;
   logic                set_period_c;
   logic                set_auto_c;
   logic                unused_tx_valid;

   // Driver TX valid is only observed; sequencing relies on the accept.
   assign unused_tx_valid = i_tx_valid;

   // Host byte decode: 0x0-0x3 are driver commands, 0x4/0x5 configure locally.
   assign host_byte_c  = i_rx_valid && (i_rx_data[3:0] <= OP_EDGE);
   assign set_period_c = i_rx_valid && (i_rx_data[3:0] == OP_PERIOD);
   assign set_auto_c   = i_rx_valid && (i_rx_data[3:0] == OP_AUTO);

   dl_sched_timer u_timer (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .set_period  (set_period_c),
      .set_auto    (set_auto_c),
      .arg         (i_rx_data[7:4]),
      .clr_pending (clr_pending_c),
      .pending     (pending)
   );

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         unload_cnt  <= '0;
         buf_full    <= 1'b0;
         buf_data    <= 8'h00;
         o_overflow  <= 1'b0;
         o_cmd_valid <= 1'b0;
         o_cmd_data  <= 8'h00;
         o_busy      <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_nxt;
         unload_cnt  <= unload_nxt;
         buf_full    <= buf_full_nxt;
         buf_data    <= buf_data_nxt;
         o_overflow  <= overflow_nxt;
         o_cmd_valid <= cmd_valid_nxt;
         o_cmd_data  <= cmd_data_nxt;
         o_busy      <= busy_nxt;
      end
   end

   // Next-state, sequencing counters, host buffer and command outputs.
   always_comb begin
      state_nxt     = state;
      wait_nxt      = wait_cnt;
      unload_nxt    = unload_cnt;
      buf_full_nxt  = buf_full;
      buf_data_nxt  = buf_data;
      overflow_nxt  = o_overflow;
      cmd_valid_nxt = 1'b0;
      cmd_data_nxt  = o_cmd_data;
      clr_pending_c = 1'b0;
      drain_buf_c   = 1'b0;

      case (state)
         IDLE: begin
            // Host buffer has strict priority over the auto sampler.
            if (buf_full)     state_nxt = HOST;
            else if (pending) state_nxt = EDGE;
         end
         HOST: begin
            cmd_valid_nxt = 1'b1;
            cmd_data_nxt  = buf_data;
            drain_buf_c   = 1'b1;
            if (buf_data[3:0] == OP_UNLOAD) begin
               state_nxt  = DRAIN;
               unload_nxt = '0;
            end else begin
               state_nxt  = IDLE;
            end
         end
         EDGE: begin
            cmd_valid_nxt = 1'b1;
            cmd_data_nxt  = {4'h0, OP_EDGE};
            clr_pending_c = 1'b1;
            wait_nxt      = WAIT_W'(P_EDGE_WAIT - 1);
            state_nxt     = WAIT;
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               state_nxt  = UNLOAD;
               unload_nxt = UNLOAD_W'(P_UNLOAD_BYTES);
            end else begin
               wait_nxt   = wait_cnt - WAIT_W'(1);
            end
         end
         UNLOAD: begin
            cmd_valid_nxt = 1'b1;
            cmd_data_nxt  = {4'h0, OP_UNLOAD};
            unload_nxt    = unload_cnt - UNLOAD_W'(1);
            state_nxt     = DRAIN;
         end
         DRAIN: begin
            if (i_tx_accept) state_nxt = (unload_cnt != '0) ? UNLOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // A byte arriving while the buffer drains refills it in the same cycle.
      if (drain_buf_c) buf_full_nxt = 1'b0;
      if (host_byte_c) begin
         if (!buf_full || drain_buf_c) begin
            buf_full_nxt = 1'b1;
            buf_data_nxt = i_rx_data;
         end else begin
            overflow_nxt = 1'b1;
         end
      end

      busy_nxt = (state_nxt != IDLE) || buf_full_nxt;
   end

endmodule
